// File: rtl/tea_pkg.sv
// Shared TEA sequencer definitions: datapath widths, controller state encoding
// and the TEA round constant.
package tea_pkg;

  localparam int unsigned TEA_BLOCK_W = 64;
  localparam int unsigned TEA_KEY_W   = 128;
  localparam int unsigned TEA_ST_W    = 2;

  localparam logic [31:0] TEA_DELTA = 32'h9E3779B9;

  localparam logic [TEA_ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [TEA_ST_W-1:0] ST_ISSUE = 2'd1;
  localparam logic [TEA_ST_W-1:0] ST_WAIT  = 2'd2;
  localparam logic [TEA_ST_W-1:0] ST_OUT   = 2'd3;

  typedef enum logic [TEA_ST_W-1:0] {
    TEA_IDLE  = ST_IDLE,
    TEA_ISSUE = ST_ISSUE,
    TEA_WAIT  = ST_WAIT,
    TEA_OUT   = ST_OUT
  } tea_ctrl_state_t;

endpackage

// File: rtl/tea_cbc_chain.sv
// CBC chaining for the TEA sequencer. It holds the chain value and the last
// accepted block, and applies the XOR on the way into and out of the core.
module tea_cbc_chain
  import tea_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   iv_load,
  input  logic [TEA_BLOCK_W-1:0] iv_in,
  input  logic                   accept,
  input  logic                   accept_mode,
  input  logic [TEA_BLOCK_W-1:0] s_data,
  input  logic                   update,
  input  logic                   mode,
  input  logic [TEA_BLOCK_W-1:0] core_out,
  output logic [TEA_BLOCK_W-1:0] core_in_c,
  output logic [TEA_BLOCK_W-1:0] result_c
);

  logic [TEA_BLOCK_W-1:0] chain;
  logic [TEA_BLOCK_W-1:0] blk;

  // Decrypt chains on the ciphertext that went in; encrypt chains on what came out.
  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
      blk   <= '0;
    end else begin
      if (iv_load) begin
        chain <= iv_in;
      end else if (update) begin
        chain <= mode ? blk : core_out;
      end
      if (accept) begin
        blk <= s_data;
      end
    end
  end

  assign core_in_c = accept_mode ? s_data : (s_data ^ chain);
  assign result_c  = mode ? (core_out ^ chain) : core_out;

endmodule

// File: rtl/tea_cbc_ctrl.sv
// Sequencer for one iterative TEA core: key/IV registers, block stream in,
// result stream out. CBC chaining is built when TEA_CBC_EN is defined, ECB otherwise.
module tea_cbc_ctrl
  import tea_pkg::*;
#(
  parameter int unsigned ROUNDS = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [TEA_KEY_W-1:0]   key_in,
  input  logic                   key_load,
  input  logic [TEA_BLOCK_W-1:0] iv_in,
  input  logic                   iv_load,
  input  logic                   mode,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [TEA_BLOCK_W-1:0] s_data,
  input  logic                   s_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [TEA_BLOCK_W-1:0] m_data,
  output logic                   m_last,
  output logic                   busy,
  output logic [TEA_BLOCK_W-1:0] core_in,
  output logic [TEA_KEY_W-1:0]   core_key,
  output logic                   core_mode,
  output logic                   core_write,
  input  logic [TEA_BLOCK_W-1:0] core_out,
  input  logic                   core_ready
);

  logic [TEA_ST_W-1:0]    state;
  logic [TEA_ST_W-1:0]    state_nxt;
  logic [TEA_KEY_W-1:0]   key_reg;
  logic                   key_valid;
  logic                   first_msg;
  logic                   last_lat;
  logic                   accept_c;
  logic                   capture_c;
  logic                   release_c;
  logic                   iv_gate_c;
  logic                   iv_start_c;
  logic                   mode_eff_c;
  logic [TEA_BLOCK_W-1:0] core_in_c;
  logic [TEA_BLOCK_W-1:0] result_c;

  // Mode is only taken from the port on the first block of a message.
  assign mode_eff_c = first_msg ? mode : core_mode;
  assign iv_start_c = iv_gate_c & (state == ST_IDLE);

`ifdef TEA_CBC_EN
  assign iv_gate_c = iv_load;

  tea_cbc_chain u_chain (
    .clk         (clk),
    .reset       (reset),
    .iv_load     (iv_start_c),
    .iv_in       (iv_in),
    .accept      (accept_c),
    .accept_mode (mode_eff_c),
    .s_data      (s_data),
    .update      (capture_c),
    .mode        (core_mode),
    .core_out    (core_out),
    .core_in_c   (core_in_c),
    .result_c    (result_c)
  );
`else
  logic unused_iv;

  assign iv_gate_c = 1'b0;
  assign core_in_c = s_data;
  assign result_c  = core_out;
  assign unused_iv = ^{iv_in, iv_load};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // core_ready is only looked at in WAIT, which masks stale or unknown flags.
  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    accept_c  = 1'b0;
    capture_c = 1'b0;
    release_c = 1'b0;
    case (state)
      ST_IDLE: begin
        s_ready = key_valid & ~key_load & ~iv_gate_c;
        if (s_valid && key_valid && !key_load && !iv_gate_c) begin
          accept_c  = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (core_ready) begin
          capture_c = 1'b1;
          state_nxt = ST_OUT;
        end
      end
      ST_OUT: begin
        if (m_ready) begin
          release_c = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_reg    <= '0;
      key_valid  <= 1'b0;
      first_msg  <= 1'b1;
      last_lat   <= 1'b0;
      core_in    <= '0;
      core_key   <= '0;
      core_mode  <= 1'b0;
      core_write <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_last     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      core_write <= accept_c;
      busy       <= (state_nxt != ST_IDLE);
      if (key_load && state == ST_IDLE) begin
        key_reg   <= key_in;
        key_valid <= 1'b1;
      end
      if (iv_start_c) begin
        first_msg <= 1'b1;
      end
      if (accept_c) begin
        core_in   <= core_in_c;
        core_key  <= key_reg;
        core_mode <= mode_eff_c;
        last_lat  <= s_last;
        first_msg <= 1'b0;
      end
      if (capture_c) begin
        m_data  <= result_c;
        m_last  <= last_lat;
        m_valid <= 1'b1;
      end
      if (release_c) begin
        m_valid <= 1'b0;
        if (m_last) begin
          first_msg <= 1'b1;
        end
      end
    end
  end

`ifndef SYNTHESIS
  logic [7:0] wait_cycles;

  always_ff @(posedge clk) begin
    if (reset || state != ST_WAIT) begin
      wait_cycles <= '0;
    end else begin
      wait_cycles <= wait_cycles + 8'd1;
    end
  end

  a_core_latency: assert property (@(posedge clk) disable iff (reset)
    (state == ST_WAIT) |-> (32'(wait_cycles) <= ROUNDS + 32'd1));
`endif

endmodule

// File: tb/tb_tea_cbc_ctrl.sv
// Bench for tea_cbc_ctrl: behavioural TEA core, reference model of the
// chaining rules, directed table, corner-case sequences and random blocks.
module tb_tea_cbc_ctrl;
  import tea_pkg::*;

  localparam int unsigned ROUNDS = 32;
  localparam int unsigned LAT    = ROUNDS + 3;
  localparam logic [63:0] CT0    = 64'h41EA3A0A_94BAA940;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] key_in;
  logic         key_load;
  logic [63:0]  iv_in;
  logic         iv_load;
  logic         mode;
  logic         s_valid;
  logic         s_ready;
  logic [63:0]  s_data;
  logic         s_last;
  logic         m_valid;
  logic         m_ready;
  logic [63:0]  m_data;
  logic         m_last;
  logic         busy;
  logic [63:0]  core_in;
  logic [127:0] core_key;
  logic         core_mode;
  logic         core_write;
  logic [63:0]  core_out;
  logic         core_ready;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  tea_cbc_ctrl #(.ROUNDS(ROUNDS)) dut (
    .clk(clk), .reset(reset), .key_in(key_in), .key_load(key_load),
    .iv_in(iv_in), .iv_load(iv_load), .mode(mode),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .core_in(core_in), .core_key(core_key), .core_mode(core_mode),
    .core_write(core_write), .core_out(core_out), .core_ready(core_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] tea_enc(input logic [63:0] v, input logic [127:0] k);
    logic [31:0] v0, v1, sum;
    v0 = v[63:32]; v1 = v[31:0]; sum = 32'd0;
    repeat (ROUNDS) begin
      sum = sum + TEA_DELTA;
      v0 = v0 + (((v1 << 4) + k[127:96]) ^ (v1 + sum) ^ ((v1 >> 5) + k[95:64]));
      v1 = v1 + (((v0 << 4) + k[63:32]) ^ (v0 + sum) ^ ((v0 >> 5) + k[31:0]));
    end
    return {v0, v1};
  endfunction

  function automatic logic [63:0] tea_dec(input logic [63:0] v, input logic [127:0] k);
    logic [31:0] v0, v1, sum;
    v0 = v[63:32]; v1 = v[31:0]; sum = 32'd0;
    repeat (ROUNDS) sum = sum + TEA_DELTA;
    repeat (ROUNDS) begin
      v1 = v1 - (((v0 << 4) + k[63:32]) ^ (v0 + sum) ^ ((v0 >> 5) + k[31:0]));
      v0 = v0 - (((v1 << 4) + k[127:96]) ^ (v1 + sum) ^ ((v1 >> 5) + k[95:64]));
      sum = sum - TEA_DELTA;
    end
    return {v0, v1};
  endfunction

  // Behavioural core: result and ready appear ROUNDS+1 edges after the write edge.
  logic [63:0] cm_res;
  int          cm_cnt = 0;
  initial begin
    core_ready = 1'b1;
    core_out   = 64'hDEAD_BEEF_0BAD_F00D;
  end
  always @(posedge clk) begin
    if (core_write) begin
      cm_res     <= core_mode ? tea_dec(core_in, core_key) : tea_enc(core_in, core_key);
      cm_cnt     <= ROUNDS + 1;
      core_ready <= 1'b0;
    end else if (cm_cnt != 0) begin
      cm_cnt <= cm_cnt - 1;
      if (cm_cnt == 1) begin
        core_ready <= 1'b1;
        core_out   <= cm_res;
      end
    end
  end

  // Reference model of the message/chaining rules.
  logic [127:0] md_key;
  logic         md_first;
  logic         md_mode;
`ifdef TEA_CBC_EN
  logic [63:0]  md_chain;
`endif

  task automatic model_reset();
    md_key = '0; md_first = 1'b1; md_mode = 1'b0;
`ifdef TEA_CBC_EN
    md_chain = '0;
`endif
  endtask

  task automatic model_iv(input logic [63:0] iv);
`ifdef TEA_CBC_EN
    md_chain = iv;
    md_first = 1'b1;
`else
    if (iv === 64'hx) md_first = 1'b1;
`endif
  endtask

  function automatic logic [63:0] model_block(input logic [63:0] d, input bit last, input bit md);
    logic [63:0] r;
    if (md_first) md_mode = md;
    md_first = 1'b0;
`ifdef TEA_CBC_EN
    if (!md_mode) begin
      r = tea_enc(d ^ md_chain, md_key);
      md_chain = r;
    end else begin
      r = tea_dec(d, md_key) ^ md_chain;
      md_chain = d;
    end
`else
    r = md_mode ? tea_dec(d, md_key) : tea_enc(d, md_key);
`endif
    if (last) md_first = 1'b1;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_ctl"}, 128'({s_ready, m_valid, m_last, busy, core_write, core_mode}), 128'd0);
    chk({nm, "_mdata"}, 128'(m_data), 128'd0);
    chk({nm, "_core_in"}, 128'(core_in), 128'd0);
    chk({nm, "_core_key"}, core_key, 128'd0);
  endtask

  task automatic load(input bit kl, input logic [127:0] k, input bit il, input logic [63:0] iv);
    key_load = kl; key_in = k; iv_load = il; iv_in = iv;
    tick();
    key_load = 1'b0; iv_load = 1'b0;
    if (kl) md_key = k;
    if (il) model_iv(iv);
  endtask

  // One block through the DUT; optional output backpressure and key poke during WAIT.
  task automatic xfer(input logic [63:0] d, input bit last, input bit md, input int hold,
                      input bit poke, output logic [63:0] res, output bit rl,
                      output int lat, output int acc, output int wt);
    bit cw_bad;
    s_valid = 1'b1; s_data = d; s_last = last; mode = md;
    if (hold > 0) m_ready = 1'b0;
    #1;
    wt = 0;
    while (!s_ready && wt < 100) begin tick(); wt++; end
    res = '0; rl = 1'b0; lat = 0; acc = cyc;
    if (!s_ready) begin
      chk("accept_timeout", 128'(s_ready), 128'd1);
      s_valid = 1'b0; m_ready = 1'b1;
      return;
    end
    tick();
    s_valid = 1'b0; s_data = {$urandom, $urandom}; mode = 1'($urandom); s_last = 1'($urandom);
    chk("core_write_pulse", 128'(core_write), 128'd1);
    cw_bad = 1'b0;
    while (!m_valid && lat < 100) begin
      tick(); lat++;
      if (core_write) cw_bad = 1'b1;
      if (poke && lat == 10) begin
        key_load = 1'b1; key_in = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        key_load = 1'b0;
      end
    end
    key_load = 1'b0;
    chk("core_write_single", 128'(cw_bad), 128'd0);
    if (!m_valid) begin
      chk("resp_timeout", 128'(m_valid), 128'd1);
      m_ready = 1'b1;
      return;
    end
    res = m_data; rl = m_last;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("backpressure_hold", 128'({m_valid, s_ready, core_write, m_data}), 128'({3'b100, res}));
    end
    m_ready = 1'b1;
    tick();
    chk("handshake_drop", 128'(m_valid), 128'd0);
  endtask

  task automatic run(input string nm, input logic [63:0] d, input bit last, input bit md,
                     input int hold, output int acc);
    logic [63:0] exp, res;
    bit rl;
    int lat, wt;
    exp = model_block(d, last, md);
    xfer(d, last, md, hold, 1'b0, res, rl, lat, acc, wt);
    chk({nm, "_data"}, 128'(res), 128'(exp));
    chk({nm, "_last"}, 128'(rl), 128'(last));
    chk({nm, "_latency"}, 128'(lat), 128'(LAT));
  endtask

  typedef struct {
    bit          ld_iv;
    logic [63:0] iv;
    logic [63:0] data;
    bit          last;
    bit          mode;
    bit          poke;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] c1, c2, res, exp;
    bit rl;
    int lat, acc, acc2, wt, dummy;

`ifdef TEA_CBC_EN
    c1 = tea_enc(64'h1, 128'h0);
    c2 = tea_enc(c1, 128'h0);
`else
    c1 = CT0;
    c2 = CT0;
`endif
    tbl[0] = '{1'b1, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0, CT0};
    tbl[1] = '{1'b1, 64'h0, CT0,   1'b1, 1'b1, 1'b1, 64'h0};
    tbl[2] = '{1'b1, 64'h1, 64'h0, 1'b0, 1'b0, 1'b0, c1};
    tbl[3] = '{1'b0, 64'h0, 64'h0, 1'b1, 1'b1, 1'b0, c2};
    tbl[4] = '{1'b1, 64'h1, c1,    1'b0, 1'b1, 1'b0, 64'h0};
    tbl[5] = '{1'b0, 64'h0, c2,    1'b1, 1'b0, 1'b0, 64'h0};

    reset = 1'b1; key_in = '0; key_load = 1'b0; iv_in = '0; iv_load = 1'b0;
    mode = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    model_reset();
    repeat (3) tick();
    chk_reset_outs("reset");
    reset = 1'b0;
    tick();

    // No key yet: input must stay blocked, and the key_load cycle itself too.
    s_valid = 1'b1; s_data = '0; s_last = 1'b1; mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("no_key_s_ready", 128'(s_ready), 128'd0);
    end
    key_load = 1'b1; key_in = '0; #1;
    chk("key_load_blocks", 128'(s_ready), 128'd0);
    tick();
    key_load = 1'b0; md_key = '0;
    chk("not_accepted_on_load", 128'(busy), 128'd0);
    exp = model_block(64'h0, 1'b1, 1'b0);
    xfer(64'h0, 1'b1, 1'b0, 0, 1'b0, res, rl, lat, acc, wt);
    chk("accept_after_load", 128'(wt), 128'd0);
    chk("ecb_enc_zero", 128'(res), 128'(CT0));
    chk("ecb_enc_model", 128'(res), 128'(exp));
    chk("ecb_enc_last", 128'(rl), 128'd1);
    chk("ecb_enc_latency", 128'(lat), 128'(LAT));

    for (int i = 0; i < 6; i++) begin
      if (tbl[i].ld_iv) load(1'b0, '0, 1'b1, tbl[i].iv);
      dummy = 0;
      exp = model_block(tbl[i].data, tbl[i].last, tbl[i].mode);
      xfer(tbl[i].data, tbl[i].last, tbl[i].mode, 0, tbl[i].poke, res, rl, lat, acc, wt);
      chk($sformatf("tbl%0d_data", i), 128'(res), 128'(tbl[i].exp));
      chk($sformatf("tbl%0d_last", i), 128'(rl), 128'(tbl[i].last));
      chk($sformatf("tbl%0d_latency", i), 128'(lat), 128'(LAT));
    end

    run("backpressure", {$urandom, $urandom}, 1'b1, 1'b0, 10, acc);
    chk("bp_s_ready_after", 128'({s_ready, busy}), 128'(2'b10));

    run("b2b_a", {$urandom, $urandom}, 1'b0, 1'b0, 0, acc);
    run("b2b_b", {$urandom, $urandom}, 1'b1, 1'b1, 0, acc2);
    chk("b2b_period", 128'(acc2 - acc), 128'(ROUNDS + 5));

    // Reset while the core is busy, then a fresh key and block.
    s_valid = 1'b1; s_data = {$urandom, $urandom}; s_last = 1'b1; mode = 1'b0;
    #1;
    chk("rst_pre_ready", 128'(s_ready), 128'd1);
    tick();
    s_valid = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    chk_reset_outs("reset_mid_wait");
    reset = 1'b0;
    model_reset();
    load(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, '0);
    run("after_reset", {$urandom, $urandom}, 1'b1, 1'b0, 0, acc);

    load(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b1, {$urandom, $urandom});
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 7))
        0: load(1'b0, '0, 1'b1, {$urandom, $urandom});
        1: load(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, '0);
        default: ;
      endcase
      run($sformatf("rand%0d", i), {$urandom, $urandom}, ($urandom_range(0, 2) == 0),
          1'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, acc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/tea_cbc_ctrl.md
# tea_cbc_ctrl

Sequencer for a single iterative TEA encrypt/decrypt core. It holds the 128-bit key and a 64-bit chaining value, and accepts a valid/ready stream of 64-bit blocks. Each block is issued to the core with a one-cycle write pulse; the controller waits for the core's ready flag and returns the result on a valid/ready output stream, applying CBC chaining when compiled in. It sits between the system stream fabric and the TEA core, which is instantiated alongside it by the parent.

## Interface
- ROUNDS, 32: round count configured in the attached core; documentation and assertion use only.
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- key_in  in  128  key; {k0,k1,k2,k3}, k0 in [127:96]
- key_load  in  1  load key_in (IDLE only)
- iv_in  in  64  CBC initial vector
- iv_load  in  1  load iv_in into chain register, start new message (IDLE only)
- mode  in  1  0 = encrypt, 1 = decrypt; sampled on first block of a message
- s_valid / s_ready  in / out  1  input block handshake
- s_data  in  64  input block {v0,v1}
- s_last  in  1  last block of message
- m_valid / m_ready  out / in  1  output handshake
- m_data  out  64  result block
- m_last  out  1  copy of s_last for this block
- busy  out  1  state != IDLE
- core_in  out  64; core_key  out  128; core_mode  out  1; core_write  out  1  core drive
- core_out  in  64; core_ready  in  1  core results

## Operation
- States: IDLE, ISSUE, WAIT, OUT.
- IDLE: s_ready = key_valid & !key_load & !iv_load. On s_valid&s_ready: latch block, last flag, and mode (if first-of-message) -> ISSUE.
- key_load in IDLE sets key register and key_valid. iv_load in IDLE sets chain := iv_in and first-of-message. Both may be asserted in the same cycle. Either one outside IDLE is ignored.
- ISSUE: core_write=1 for exactly one cycle; core_in/core_key/core_mode are registered, stable from ISSUE until the next ISSUE -> WAIT.
- WAIT: on core_ready=1, register m_data/m_last -> OUT. core_ready is never sampled outside WAIT; it is X before the first write.
- OUT: m_valid=1, m_data held; on m_ready -> IDLE. If m_last=1, set first-of-message.
- Encrypt CBC: core_in = s_data ^ chain; chain := core_out.
- Decrypt CBC: core_in = s_data; m_data = core_out ^ chain; chain := latched s_data.
- Chain update occurs at WAIT->OUT.
- Mode is held across a message. A change of mode mid-message is ignored until s_last completes or iv_load is applied.

## Timing
- Reset values: s_ready=0, m_valid=0, m_data=0, m_last=0, busy=0, core_write=0, core_in=0, core_key=0, core_mode=0, key_valid=0, chain=0, first-of-message=1, state IDLE.
- Latency, ROUNDS=32: accept edge A; core write edge A+1; core_ready high after A+34; m_valid high after A+35 (ROUNDS+3).
- Back-to-back period, with m_ready held high: ROUNDS+5 cycles.
- Reset mid-operation: everything returns to its reset value. The core is not reset; its next write pulse restarts it, and stale core_ready is masked because it is only sampled in WAIT.
- m_valid must not drop and m_data must not change until the handshake completes.

## Configuration
- TEA_CBC_EN defined: CBC chaining as described.
- TEA_CBC_EN undefined: ECB mode.
  - chain register and XORs removed.
  - core_in = s_data, m_data = core_out.
  - iv_in/iv_load ports remain but are ignored.
  - first-of-message logic still governs when mode is latched.

## Structure
- Shared package tea_pkg holds:
  - TEA_BLOCK_W=64 and TEA_KEY_W=128.
  - tea_ctrl_state_t enum (IDLE/ISSUE/WAIT/OUT).
  - TEA_DELTA=32'h9E3779B9, for bench use.
- One natural sub-module: tea_cbc_chain, which holds the chain register, XOR-in and XOR-out. It is instantiated only under TEA_CBC_EN.

## Test plan
- ECB encrypt:
  - Stimulus: key 0, mode 0, s_data 0, s_last=1.
  - Required: m_data=64'h41EA3A0A_94BAA940, m_last=1, m_valid rises exactly 35 cycles after the accept edge.
- ECB round trip:
  - Stimulus: m_data from the previous test, mode 1.
  - Required: m_data=0.
- CBC, TEA_CBC_EN defined:
  - Stimulus: key 0, iv 64'h1, two zero blocks, encrypt.
  - Required: block 2 = E(block1_ct). Decrypting both blocks with iv 64'h1 returns two zero blocks.
- Backpressure:
  - Stimulus: hold m_ready=0 for 10 cycles in OUT.
  - Required: m_data stable, s_ready=0, core_write stays 0. Release gives one handshake, then s_ready=1 on the next cycle.
- Load gating:
  - Stimulus: s_valid before any key_load.
  - Required: s_ready stays 0. key_load together with s_valid → not accepted that cycle, accepted next cycle. key_load during WAIT → key unchanged.
- Reset mid-WAIT:
  - Stimulus: assert reset 10 cycles after accept.
  - Required: all outputs at reset values next cycle. After re-key and a new block, the result is correct and has the full 35-cycle latency.
